// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared state encodings for the memory port arbiter
package mem_port_arbiter_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE   = 3'd0,
        ARB_DBUSY  = 3'd1,
        ARB_IFBUSY = 3'd2,
        ARB_IFDROP = 3'd3,
        ARB_HALT   = 3'd4
    } arb_state_e;

    // True while a memory request is outstanding, whether its result is kept or not
    function automatic logic arb_in_flight(arb_state_e s);
        return (s == ARB_DBUSY) || (s == ARB_IFBUSY) || (s == ARB_IFDROP);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - pipeline and memory-side signals of the memory port arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_done;
    logic [DATA_W-1:0] if_rdata;
    logic              if_stall;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;
    logic              d_stall;

    logic              halt_req;
    logic              halted;

    logic              mem_valid;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_done;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_error;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, if_flush,
        output if_done, if_rdata, if_stall,
        input  d_read, d_write, d_addr, d_wdata,
        output d_done, d_rdata, d_stall,
        input  halt_req,
        output halted,
        output mem_valid, mem_we, mem_addr, mem_wdata,
        input  mem_done, mem_rdata,
        output mem_error
    );

    // Pipeline and memory side
    modport master (
        output if_req, if_addr, if_flush,
        input  if_done, if_rdata, if_stall,
        output d_read, d_write, d_addr, d_wdata,
        input  d_done, d_rdata, d_stall,
        output halt_req,
        input  halted,
        input  mem_valid, mem_we, mem_addr, mem_wdata,
        output mem_done, mem_rdata,
        input  mem_error
    );

endinterface

// File: rtl/mem_port_arbiter_arb_watchdog.sv
// rtl/mem_port_arbiter_arb_watchdog.sv - memory response watchdog with sticky error
module arb_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic busy_i,
    input  logic done_i,
    output logic expire_o,
    output logic error_o
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             error_q, error_d;

    // Expire on the edge that would complete the TIMEOUT-th waiting cycle; a
    // response arriving on that same edge still wins.
    assign expire_o = busy_i && !done_i && (cnt_q == CNT_W'(TIMEOUT - 1));
    assign error_o  = error_q;

    // Next count and sticky error
    always_comb begin
        cnt_d   = cnt_q;
        error_d = error_q | expire_o;
        if (clr_i) begin
            cnt_d = '0;
        end else if (busy_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter and error registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            error_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            error_q <= error_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch and data access
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_port_arbiter_if.slave    bus
);
    arb_state_e        state_q;
    logic              halt_pend_q;
    logic              halted_q;
    logic              if_done_q;
    logic              d_done_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              mem_valid_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic d_req;
    logic f_req;
    logic halt_now;
    logic grant;
    logic in_halt;
    logic wd_expire;
    logic wd_error;

    // A request whose done pulse is showing this cycle is already serviced;
    // the pipeline only moves on at the coming edge, so it must not be granted again.
    assign d_req    = (bus.d_read | bus.d_write) & ~d_done_q;
    assign f_req    = bus.if_req & ~if_done_q & ~bus.if_flush;
    assign halt_now = bus.halt_req | halt_pend_q;
    assign grant    = (state_q == ARB_IDLE) && !halt_now && (d_req || f_req);
    assign in_halt  = (state_q == ARB_HALT);

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (grant),
        .busy_i   (arb_in_flight(state_q)),
        .done_i   (bus.mem_done),
        .expire_o (wd_expire),
        .error_o  (wd_error)
    );

    // Arbitration FSM with registered memory request and completion outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ARB_IDLE;
            halt_pend_q <= 1'b0;
            halted_q    <= 1'b0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            // Remember an ecall seen mid-access so it takes effect once idle
            halt_pend_q <= halt_pend_q | bus.halt_req;
            case (state_q)
                ARB_IDLE: begin
                    if (halt_now) begin
                        state_q  <= ARB_HALT;
                        halted_q <= 1'b1;
                    end else if (d_req) begin
                        // MEM stage holds the older instruction, so data goes first
                        state_q     <= ARB_DBUSY;
                        mem_valid_q <= 1'b1;
                        mem_we_q    <= bus.d_write;
                        mem_addr_q  <= bus.d_addr;
                        mem_wdata_q <= bus.d_wdata;
                    end else if (f_req) begin
                        state_q     <= ARB_IFBUSY;
                        mem_valid_q <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= bus.if_addr;
                        mem_wdata_q <= '0;
                    end
                end
                ARB_DBUSY: begin
                    if (bus.mem_done) begin
                        d_rdata_q   <= bus.mem_rdata;
                        d_done_q    <= 1'b1;
                        mem_valid_q <= 1'b0;
                        state_q     <= ARB_IDLE;
                    end else if (wd_expire) begin
                        mem_valid_q <= 1'b0;
                        state_q     <= ARB_IDLE;
                    end
                end
                ARB_IFBUSY: begin
                    if (bus.mem_done) begin
                        // A flush arriving with the response still discards it
                        if (!bus.if_flush) begin
                            if_rdata_q <= bus.mem_rdata;
                            if_done_q  <= 1'b1;
                        end
                        mem_valid_q <= 1'b0;
                        state_q     <= ARB_IDLE;
                    end else if (wd_expire) begin
                        mem_valid_q <= 1'b0;
                        state_q     <= ARB_IDLE;
                    end else if (bus.if_flush) begin
                        state_q <= ARB_IFDROP;
                    end
                end
                ARB_IFDROP: begin
                    if (bus.mem_done || wd_expire) begin
                        mem_valid_q <= 1'b0;
                        state_q     <= ARB_IDLE;
                    end
                end
                ARB_HALT: begin
                    state_q <= ARB_HALT;
                end
                default: begin
                    state_q     <= ARB_IDLE;
                    mem_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.if_done   = if_done_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_done    = d_done_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.halted    = halted_q;
    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_error = wd_error;

    // A halted core must not sit waiting on the memory port
    assign bus.if_stall = reset & ~in_halt & bus.if_req & ~if_done_q;
    assign bus.d_stall  = reset & ~in_halt & (bus.d_read | bus.d_write) & ~d_done_q;

endmodule
